pwm_basico: RTL and testbench



---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_core.sv | 34 +++
 rtl/pwm_basico.sv | 84 ++++++++
 tb/tb_pwm_basico.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default parameters for the pwm_basico duty-cycle sweeper.
package pwm_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int R_DEF    = 8;
  localparam int HOLD_DEF = 8;
  localparam int STEP_DEF = 32;

endpackage

// File: rtl/pwm_core.sv
// Free-running R-bit period counter with duty comparator and period-end strobe.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int R = R_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [R-1:0] ciclo,
  output logic         pwm_out,
  output logic         period_end
);

  localparam logic [R-1:0] CNT_ONE  = R'(1);
  localparam logic [R-1:0] CNT_LAST = '1;

  logic [R-1:0] cnt;

  // Period counter, wraps naturally from all-ones back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Output decoded straight from registers so each period starts high at cnt=0.
  always_comb begin
    pwm_out    = (cnt < ciclo);
    period_end = (cnt == CNT_LAST);
  end

endmodule

// File: rtl/pwm_basico.sv
// PWM demo source: triangle sweep of the duty value, held for HOLD periods per step.
module pwm_basico
  import pwm_pkg::*;
#(
  parameter int R    = R_DEF,
  parameter int HOLD = HOLD_DEF,
  parameter int STEP = STEP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  output logic [R-1:0] ciclo,
  output logic         pwm_out
);

  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [R:0]    STEP_EXT  = (R + 1)'(STEP);
  localparam logic [R:0]    DUTY_MAX  = {1'b0, {R{1'b1}}};

  logic          period_end;
  logic [HW-1:0] hold;
  dir_t          dir;
  dir_t          dir_next;
  logic [R-1:0]  ciclo_next;
  logic [R:0]    sum;

  pwm_core #(
    .R(R)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .ciclo      (ciclo),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  // Next duty/direction; one bit of headroom lets the saturation tests see overflow.
  always_comb begin
    ciclo_next = ciclo;
    dir_next   = dir;
    sum        = {1'b0, ciclo} + STEP_EXT;
    case (dir)
      DIR_UP: begin
        if (sum <= DUTY_MAX) begin
          ciclo_next = sum[R-1:0];
        end else begin
          ciclo_next = '1;
          dir_next   = DIR_DOWN;
        end
      end
      DIR_DOWN: begin
        if ({1'b0, ciclo} >= STEP_EXT) begin
          ciclo_next = ciclo - STEP_EXT[R-1:0];
        end else begin
          ciclo_next = '0;
          dir_next   = DIR_UP;
        end
      end
      default: begin
        ciclo_next = '0;
        dir_next   = DIR_UP;
      end
    endcase
  end

  // Sweep state advances only on the edge where the period counter wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold  <= '0;
      dir   <= DIR_UP;
      ciclo <= '0;
    end else if (period_end) begin
      if (hold == HOLD_LAST) begin
        hold  <= '0;
        ciclo <= ciclo_next;
        dir   <= dir_next;
      end else begin
        hold <= hold + HOLD_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pwm_basico.sv
// Directed bench for pwm_basico: default sweep, mid-period reset, and a small R=4 instance.
module tb_pwm_basico;

  logic       clk = 1'b0;
  logic       reset_a;
  logic       reset_b;
  logic [7:0] ciclo_a;
  logic       pwm_a;
  logic [3:0] ciclo_b;
  logic       pwm_b;

  int vectors = 0;
  int miscompares = 0;

  int seq_a[24] = '{0, 32, 64, 96, 128, 160, 192, 224, 255, 223, 191, 159,
                    127, 95, 63, 31, 0, 32, 64, 96, 128, 0, 32, 64};
  int seq_b[10] = '{0, 5, 10, 15, 15, 10, 5, 0, 0, 5};

  pwm_basico u_dut_a (
    .clk     (clk),
    .reset   (reset_a),
    .ciclo   (ciclo_a),
    .pwm_out (pwm_a)
  );

  pwm_basico #(
    .R    (4),
    .HOLD (1),
    .STEP (5)
  ) u_dut_b (
    .clk     (clk),
    .reset   (reset_b),
    .ciclo   (ciclo_b),
    .pwm_out (pwm_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Observes one full PWM period starting at the cnt=0 sample; ends on the next cnt=0 sample.
  task automatic run_period(input int sel, input int exp_c, input int plen, input string tag);
    int   high_cnt;
    int   bad_duty;
    int   bad_shape;
    int   c;
    logic p;
    high_cnt  = 0;
    bad_duty  = 0;
    bad_shape = 0;
    for (int i = 0; i < plen; i++) begin
      if (sel == 0) begin
        c = int'(ciclo_a);
        p = pwm_a;
      end else begin
        c = int'(ciclo_b);
        p = pwm_b;
      end
      if (c != exp_c) bad_duty++;
      if (p !== ((i < exp_c) ? 1'b1 : 1'b0)) bad_shape++;
      if (p === 1'b1) high_cnt++;
      @(negedge clk);
    end
    check({tag, "_duty_samples_off"}, bad_duty, 0);
    check({tag, "_shape_samples_off"}, bad_shape, 0);
    check({tag, "_high_count"}, high_cnt, exp_c);
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("rst_ciclo_a", int'(ciclo_a), 0);
      check("rst_pwm_a", int'(pwm_a), 0);
      check("rst_ciclo_b", int'(ciclo_b), 0);
    end

    // Default sweep through the top and bottom turnarounds, then back up to 128.
    reset_a = 1'b0;
    for (int k = 0; k < 21; k++) begin
      for (int p = 0; p < 8; p++) begin
        if (k < 20) run_period(0, seq_a[k], 256, $sformatf("a_step%0d", k));
        else if (p < 3) run_period(0, seq_a[k], 256, $sformatf("a_step%0d", k));
      end
    end

    // Mid-period reset at cnt=100 while ciclo=128.
    repeat (100) @(negedge clk);
    check("mid_ciclo_before", int'(ciclo_a), 128);
    check("mid_pwm_before", int'(pwm_a), 1);
    reset_a = 1'b1;
    @(negedge clk);
    check("mid_ciclo_after", int'(ciclo_a), 0);
    check("mid_pwm_after", int'(pwm_a), 0);
    @(negedge clk);
    check("mid_ciclo_held", int'(ciclo_a), 0);
    reset_a = 1'b0;
    for (int k = 21; k < 24; k++) begin
      for (int p = 0; p < 8; p++) begin
        run_period(0, seq_a[k], 256, $sformatf("a_restart%0d", k));
      end
    end

    // Small instance: one period per step, saturating ends repeat once.
    reset_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      run_period(1, seq_b[k], 16, $sformatf("b_step%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
